// File: rtl/pyc_sync_mem_dp_arb.sv
// pyc_sync_mem_dp_arb: zero-init sweep, then round-robin sharing of the 2R1W memory's read ports plus write pass-through.
module pyc_sync_mem_dp_arb #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int NREQ       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [NREQ*DATA_WIDTH-1:0] rsp_data,
    input  logic                       wr_valid,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [DATA_WIDTH/8-1:0]    wr_strb,
    output logic                       wr_ready,
    output logic                       mem_ren0,
    output logic [ADDR_WIDTH-1:0]      mem_raddr0,
    input  logic [DATA_WIDTH-1:0]      mem_rdata0,
    output logic                       mem_ren1,
    output logic [ADDR_WIDTH-1:0]      mem_raddr1,
    input  logic [DATA_WIDTH-1:0]      mem_rdata1,
    output logic                       mem_wvalid,
    output logic [ADDR_WIDTH-1:0]      mem_waddr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [DATA_WIDTH/8-1:0]    mem_wstrb
);
    localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int RW = $clog2(NREQ);
    typedef enum logic {INIT, RUN} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rr_q, rr_d, idx;
    logic            v0_q, v0_d, v1_q, v1_d;
    logic [RW-1:0]   id0_q, id0_d, id1_q, id1_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rr_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            id0_q   <= '0;
            id1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            id0_q   <= id0_d;
            id1_q   <= id1_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        idx        = '0;
        id0_d      = '0;
        id1_d      = '0;
        init_done  = state_q == RUN;
        req_ready  = '0;
        wr_ready   = 1'b0;
        mem_ren0   = 1'b0;
        mem_ren1   = 1'b0;
        mem_raddr0 = '0;
        mem_raddr1 = '0;
        mem_wvalid = 1'b1;
        mem_waddr  = ADDR_WIDTH'(cnt_q);
        mem_wdata  = '0;
        mem_wstrb  = '1;
        if (state_q == INIT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(DEPTH - 1) ? RUN : INIT;
        end else begin
            wr_ready   = 1'b1;
            mem_wvalid = wr_valid;
            mem_waddr  = wr_addr;
            mem_wdata  = wr_data;
            mem_wstrb  = wr_strb;
            // Scan from rr: the first valid requester takes port 0, the next takes port 1.
            for (int k = 0; k < NREQ; k++) begin
                idx = RW'((int'(rr_q) + k) % NREQ);
                if (req_valid[idx] && !mem_ren0) begin
                    mem_ren0       = 1'b1;
                    mem_raddr0     = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                    id0_d          = idx;
                    req_ready[idx] = 1'b1;
                end else if (req_valid[idx] && !mem_ren1) begin
                    mem_ren1       = 1'b1;
                    mem_raddr1     = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                    id1_d          = idx;
                    req_ready[idx] = 1'b1;
                end
            end
            rr_d = mem_ren1 ? RW'((int'(id1_d) + 1) % NREQ) :
                   mem_ren0 ? RW'((int'(id0_d) + 1) % NREQ) : rr_q;
        end
        v0_d = mem_ren0;
        v1_d = mem_ren1;
    end
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (v0_q) begin
            rsp_valid[id0_q]                          = 1'b1;
            rsp_data[id0_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata0;
        end
        if (v1_q) begin
            rsp_valid[id1_q]                          = 1'b1;
            rsp_data[id1_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata1;
        end
    end
endmodule

// File: tb/tb_pyc_sync_mem_dp_arb.sv
// tb_pyc_sync_mem_dp_arb: scoreboard bench with a write-first 2R1W memory model behind the arbiter.
module tb_pyc_sync_mem_dp_arb;
    localparam int AW = 8, DW = 64, DEPTH = 16, NREQ = 4;
    logic            clk = 1'b0, rst;
    logic            init_done, wr_ready, wr_valid;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] rsp_data;
    logic [AW-1:0]   wr_addr, mem_raddr0, mem_raddr1, mem_waddr;
    logic [DW-1:0]   wr_data, mem_rdata0, mem_rdata1, mem_wdata;
    logic [7:0]      wr_strb, mem_wstrb;
    logic            mem_ren0, mem_ren1, mem_wvalid;
    typedef struct { int id; logic [DW-1:0] d; } ent_t;
    ent_t            q[$];
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   exp_mem [DEPTH];
    int              total = 0, bad = 0;

    pyc_sync_mem_dp_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready),
        .mem_ren0(mem_ren0), .mem_raddr0(mem_raddr0), .mem_rdata0(mem_rdata0),
        .mem_ren1(mem_ren1), .mem_raddr1(mem_raddr1), .mem_rdata1(mem_rdata1),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (a >= DEPTH) return '0;
        if (mem_wvalid && mem_waddr == a) return merge(mem[a[3:0]], mem_wdata, mem_wstrb);
        return mem[a[3:0]];
    endfunction

    // Memory model: registered reads, write-first forwarding, zero data out of range.
    always @(posedge clk) begin
        if (mem_ren0) mem_rdata0 <= rd(mem_raddr0);
        if (mem_ren1) mem_rdata1 <= rd(mem_raddr1);
        if (mem_wvalid && mem_waddr < DEPTH) mem[mem_waddr[3:0]] <= merge(mem[mem_waddr[3:0]], mem_wdata, mem_wstrb);
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_rsp();
        logic [NREQ-1:0] m;
        ent_t e;
        m = '0;
        while (q.size() > 0) begin
            e = q.pop_front();
            m[e.id] = 1'b1;
            chk($sformatf("rsp_data[%0d]", e.id), rsp_data[e.id*DW +: DW], e.d);
        end
        chk("rsp_valid", DW'(rsp_valid), DW'(m));
        for (int i = 0; i < NREQ; i++) if (!m[i]) chk($sformatf("rsp_data_idle[%0d]", i), rsp_data[i*DW +: DW], '0);
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [3:0] rdy,
                        input logic wv, input logic [7:0] wa, input logic [DW-1:0] wd, input logic [7:0] ws);
        logic [7:0] ra;
        ent_t e;
        @(negedge clk);
        check_rsp();
        req_valid = v; req_addr = a;
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws;
        #1;
        chk("req_ready", DW'(req_ready), DW'(rdy));
        chk("wr_ready", DW'(wr_ready), 1);
        chk("mem_wvalid", DW'(mem_wvalid), DW'(wv));
        if (wv && wa < DEPTH) exp_mem[wa[3:0]] = merge(exp_mem[wa[3:0]], wd, ws);
        for (int i = 0; i < NREQ; i++) if (rdy[i]) begin
            ra = a[8*i +: 8];
            e.id = i;
            e.d = ra < DEPTH ? exp_mem[ra[3:0]] : '0;
            q.push_back(e);
        end
    endtask

    task automatic sweep();
        req_valid = '1; wr_valid = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            chk("init_waddr", DW'(mem_waddr), DW'(c));
            chk("init_wvalid", DW'(mem_wvalid), 1);
            chk("init_wdata", mem_wdata, '0);
            chk("init_wstrb", DW'(mem_wstrb), 64'hFF);
            chk("init_done_low", DW'(init_done), 0);
            chk("init_ready", DW'({req_ready, wr_ready, mem_ren0, mem_ren1}), 0);
            @(negedge clk);
        end
        #1 chk("init_done", DW'(init_done), 1);
        req_valid = '0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        rst = 1'b1; req_valid = '1; req_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_init_done", DW'(init_done), 0);
        chk("rst_rsp_valid", DW'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data[DW-1:0] | rsp_data[2*DW-1:DW], '0);
        chk("rst_req_ready", DW'(req_ready), 0);
        chk("rst_wr_ready", DW'(wr_ready), 0);
        chk("rst_ren", DW'({mem_ren0, mem_ren1}), 0);
        chk("rst_wvalid", DW'(mem_wvalid), 1);
        rst = 1'b0;
        sweep();
        step(4'b1000, {8'd3, 8'd0, 8'd0, 8'd0}, 4'b1000, 0, 0, 0, 0);
        step(4'b1111, {8'd15, 8'd9, 8'd7, 8'd0}, 4'b0011, 0, 0, 0, 0);
        step(4'b0110, {8'd0, 8'd2, 8'd1, 8'd0}, 4'b0110, 0, 0, 0, 0);
        step(4'b1111, {8'd4, 8'd6, 8'd8, 8'd10}, 4'b1100, 0, 0, 0, 0);
        step(4'b0000, 32'd0, 4'b0000, 1, 8'd1, 64'hA1A2_A3A4_A5A6_A7A8, 8'hFF);
        step(4'b0000, 32'd0, 4'b0000, 1, 8'd2, 64'hB1B2_B3B4_B5B6_B7B8, 8'hFF);
        step(4'b0000, 32'd0, 4'b0000, 1, 8'd3, 64'hC1C2_C3C4_C5C6_C7C8, 8'hF0);
        step(4'b0000, 32'd0, 4'b0000, 1, 8'd12, 64'h0123_4567_89AB_CDEF, 8'hFF);
        step(4'b1111, {8'd12, 8'd3, 8'd2, 8'd1}, 4'b0011, 1, 8'd9, 64'h9999_0000_9999_0000, 8'hFF);
        step(4'b1111, {8'd20, 8'd3, 8'd12, 8'd2}, 4'b1100, 0, 0, 0, 0);
        step(4'b1111, {8'd9, 8'd1, 8'd12, 8'd3}, 4'b0011, 0, 0, 0, 0);
        step(4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, 4'b0001, 1, 8'd5, 64'h1122_3344_5566_7788, 8'h0F);
        step(4'b0000, 32'd0, 4'b0000, 0, 0, 0, 0);
        chk("collision_model", exp_mem[5], 64'h0000_0000_5566_7788);
        step(4'b1111, {8'd1, 8'd2, 8'd3, 8'd4}, 4'b0110, 0, 0, 0, 0);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        #1;
        chk("midrst_rsp_valid", DW'(rsp_valid), 0);
        chk("midrst_init_done", DW'(init_done), 0);
        rst = 1'b0;
        sweep();
        step(4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, 4'b0001, 0, 0, 0, 0);
        step(4'b0000, 32'd0, 4'b0000, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
